// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared definitions for the two-port ALU arbiter slice: ALU opcode
//   constants, the arbiter state encoding and the fill bit used to build the
//   result returned for unsupported opcodes.
//   Ports: none (package).
package alu_arb_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_LUI   = 5'd3;
  localparam logic [4:0] OP_PASSA = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;

  // Unsupported opcodes return a result with every bit equal to this value.
  localparam logic RES_DEFAULT_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between two requesters and the ALU arbiter.
//   Slice i of req_a/req_b/req_op belongs to requester i.
//   Signals:
//     req_valid/req_ready  request handshake, bit i = requester i
//     req_a/req_b/req_op   packed per-requester operands and opcode
//     rsp_valid/rsp_ready  response handshake, bit i = requester i
//     rsp_res/rsp_eq/rsp_gt shared result bus for the flagged requester
//     busy                 arbiter is not idle
//   Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_res;
  logic                rsp_eq;
  logic                rsp_gt;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_eq, rsp_gt, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_eq, rsp_gt, busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu
//   Purely combinational ALU shared by the arbiter.
//   Ports:
//     a, b  operands (DATA_W)
//     op    opcode (OP_W): 0 add, 1 sub, 2 or, 3 lui (b << 16), 4 pass a,
//           5 b shifted left by a[4:0], 6 signed a < b; others -> all ones
//     res   result (DATA_W), arithmetic wraps modulo 2^DATA_W
//     eq    a == b
//     gt    signed a > signed b
module alu
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] res,
  output logic              eq,
  output logic              gt
);

  logic slt;

  always_comb begin
    slt = $signed(a) < $signed(b);
    res = {DATA_W{RES_DEFAULT_FILL}};
    case (op)
      OP_W'(OP_ADD):   res = a + b;
      OP_W'(OP_SUB):   res = a - b;
      OP_W'(OP_OR):    res = a | b;
      OP_W'(OP_LUI):   res = b << 16;
      OP_W'(OP_PASSA): res = a;
      OP_W'(OP_SLL):   res = b << a[4:0];
      OP_W'(OP_SLT):   res = {{(DATA_W-1){1'b0}}, slt};
      default:         res = {DATA_W{RES_DEFAULT_FILL}};
    endcase
  end

  assign eq = (a == b);
  assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared combinational ALU. A request is
//   granted in IDLE, evaluated in EXEC and presented in RESP until the granted
//   requester takes it, giving one request every three cycles at best.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_arbiter_if.slave (request/response handshakes, busy)
//   Build option:
//     ALU_ARB_FIXED_PRIO_EN  defined: port 0 always wins simultaneous
//                            requests; undefined: round-robin on last grant.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                eq_q, eq_d;
  logic                gt_q, gt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic                sel;
  logic                accept;
  logic [1:0]          req_ready_c;
  logic [1:0]          rsp_valid_c;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_eq;
  logic                alu_gt;

  // Port chosen if a grant happens this cycle; with a single valid request
  // that port wins outright, otherwise the tie-break policy decides.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    sel = ~bus.req_valid[0];
`else
    if (&bus.req_valid) sel = ~last_grant_q;
    else                sel = ~bus.req_valid[0];
`endif
  end

  assign accept = (state_q == ST_IDLE) && (|bus.req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|bus.req_valid)          state_d = ST_EXEC;
      ST_EXEC:                              state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready[grant_q])  state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    if (accept)               req_ready_c[sel]     = 1'b1;
    if (state_q == ST_RESP)   rsp_valid_c[grant_q] = 1'b1;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_eq    = eq_q;
  assign bus.rsp_gt    = gt_q;
  assign bus.busy      = (state_q != ST_IDLE);

  // Operands are captured on the grant; the result registers load at the end
  // of EXEC and then hold through RESP regardless of backpressure.
  always_comb begin
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    if (accept) begin
      grant_d = sel;
      a_d     = sel ? bus.req_a[DATA_W +: DATA_W] : bus.req_a[0 +: DATA_W];
      b_d     = sel ? bus.req_b[DATA_W +: DATA_W] : bus.req_b[0 +: DATA_W];
      op_d    = sel ? bus.req_op[OP_W +: OP_W]    : bus.req_op[0 +: OP_W];
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = sel;
`endif
    end
    if (state_q == ST_EXEC) begin
      res_d = alu_res;
      eq_d  = alu_eq;
      gt_d  = alu_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res),
    .eq  (alu_eq),
    .gt  (alu_gt)
  );

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 32, operand/result width
  OP_W, 5, ALU opcode width
REQ-002 Ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  2  request valid, bit i = requester i
  req_ready  out  2  request accepted this cycle, bit i
  req_a  in  2*DATA_W  operand A, slice i
  req_b  in  2*DATA_W  operand B, slice i
  req_op  in  2*OP_W  opcode, slice i (0 add, 1 sub, 2 or, 3 lui, 4 passA, 5 sll B by A[4:0], 6 signed slt)
  rsp_valid  out  2  response valid, bit i, at most one bit set
  rsp_ready  in  2  response taken, bit i
  rsp_res  out  DATA_W  ALU result for the requester flagged in rsp_valid
  rsp_eq  out  1  A equals B
  rsp_gt  out  1  signed A greater than B
  busy  out  1  high in any state other than IDLE
REQ-003 Clocking: one clock, clk; reset is asynchronous and active-low, port rst_n.

Function
REQ-004 FSM SHALL have states IDLE, EXEC, RESP; sole owner of one shared ALU instance.
REQ-005 IDLE: if any req_valid bit is set, the arbiter SHALL grant one port, assert only that req_ready bit combinationally in the same cycle, capture its a/b/op into operand registers, latch grant index, go to EXEC.
REQ-006 req_ready SHALL be 0 in EXEC and RESP; the ungranted requester SHALL wait with req_valid held.
REQ-007 Round-robin: with both bits valid, the port not in last_grant SHALL win; with one valid, that port SHALL win regardless of last_grant; last_grant SHALL update on every grant.
REQ-008 EXEC: ALU SHALL evaluate the captured operands; result, eq and gt SHALL be registered at the end of EXEC; next state RESP.
REQ-009 RESP: rsp_valid[grant] SHALL be 1 and rsp_res/eq/gt SHALL be held stable until rsp_ready[grant]=1; then IDLE. rsp_ready on the other bit SHALL be ignored.
REQ-010 Latency: acceptance in cycle N gives rsp_valid in cycle N+2; peak throughput 1 request per 3 cycles.
REQ-011 Unknown opcode (7..31) SHALL yield rsp_res = all ones; eq and gt are still computed.
REQ-012 Arithmetic SHALL be modulo 2^DATA_W; add/sub overflow is silently wrapped, with no flag.
REQ-013 In RESP, a new req_valid SHALL NOT be accepted until the cycle after the response handshake.

Reset
REQ-014 rst_n low SHALL immediately force state IDLE, last_grant=1 (port 0 wins first), req_ready=0, rsp_valid=0, rsp_res=0, rsp_eq=0, rsp_gt=0, busy=0, and operand registers to 0.
REQ-015 A reset in EXEC or RESP SHALL discard the in-flight request without a response.

Configuration
REQ-016 With ALU_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win simultaneous requests and last_grant SHALL be unused; without it, REQ-007 round-robin SHALL apply.

Structure
REQ-017 Shared package alu_arb_pkg SHALL hold the opcode constants (0..6), the state encoding, and the default result constant.
REQ-018 One sub-module, alu (the existing combinational ALU), SHALL be instantiated unmodified; the arbiter SHALL hold all sequential logic.

Verification
REQ-019 Reset release, then port0 op=0 a=5 b=7 -> req_ready=01 same cycle, rsp_valid=01 two cycles later, rsp_res=12, eq=0, gt=0.
REQ-020 Both valid in the same cycle after reset: port0 op=1 a=3 b=5, port1 op=6 a=-1 b=1 -> port0 first, res=0xFFFFFFFE; then port1, res=1; order 0,1 (with the macro also 0,1, and a repeated pair gives 0,0 with the macro versus 1,0 round-robin if last=0).
REQ-021 Backpressure: rsp_ready=0 for 5 cycles in RESP, op=3 b=0x1234 -> rsp_res=0x12340000 held stable, req_ready stays 00 throughout.
REQ-022 op=5 a=0x24 b=1 -> res=0x10 (shift by a[4:0]=4); op=9 -> res=0xFFFFFFFF; op=0 a=0xFFFFFFFF b=1 -> res=0.
REQ-023 rst_n low during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next grant goes to port 0.
